operand_fwd_ctrl: RTL
=====================

# operand_fwd_ctrl

Sequencing controller for the 5-to-1 32-bit operand muxes at the EX-stage inputs of the five-stage RISC-V pipeline. Keeps an internal scoreboard of in-flight destination registers, drives the 3-bit selects of the operand-A and operand-B muxes, and generates load-use stalls, pipeline bubbles and memory-wait freezes. Sits beside the ID/EX pipeline register; its selects are registered and aligned to the instruction occupying EX.

## Interface
- None (register address width fixed at 5, select width fixed at 3)

- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  operand actually reads register
- id_alt_a, id_alt_b  in  1 each  operand takes PC (A) / immediate (B) instead of a register
- id_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect; kill ID and EX
- mem_wait  in  1  data memory not ready; freeze pipeline
- fwd_a_sel, fwd_b_sel  out  3 each  mux selects, valid while instruction in EX
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- freeze  out  1  hold all pipeline registers

## Operation
- Select encoding: 000 register file, 001 EX/MEM ALU result, 010 MEM/WB result, 011 WB-hold register, 100 alternate (PC/immediate); 101–111 never driven.
- Scoreboard: three slots EX, MEM, WB; each {valid, rd, reg_write, is_load}. Advance: ID→EX, EX→MEM, MEM→WB, WB drops. rd==0 or reg_write==0 never matches.
- Per operand, evaluated on ID contents: alt → 100; else unused → 000; else match EX slot → 001; else match MEM → 010; else match WB → 011; else 000. Youngest producer wins.
- Load-use: EX slot is_load and matches a used ID source → stall=1, bubble=1 for one cycle; EX slot becomes invalid, ID held; next cycle the load sits in MEM and the consumer gets 010.
- FSM states RUN, LOAD_STALL, FREEZE.
  - RUN: mem_wait → FREEZE; load-use hazard → LOAD_STALL; else advance.
  - LOAD_STALL: one cycle; scoreboard shifts with a bubble into EX; → RUN (or FREEZE if mem_wait).
  - FREEZE: freeze=1, stall=1, scoreboard and selects hold; leave to RUN when mem_wait=0.
- flush (not in FREEZE): ID and EX slots invalidated, bubble=1, selects for the bubble = 000; overrides load-use stall. flush during FREEZE ignored; the branch unit holds it until freeze drops.

## Timing
- Reset: all slots invalid, fwd_a_sel=fwd_b_sel=000, stall=bubble=freeze=0, state RUN.
- Selects computed in ID cycle t, registered, valid during t+1 (EX). Latency 1.
- stall/bubble/freeze combinational from state and current inputs, same cycle.
- Back-to-back dependent ALU ops: no stall. Load followed by consumer: exactly one stall cycle. Load followed by independent instruction and then a consumer: no stall, sel 010.
- Reset mid-stall or mid-freeze: next cycle is RUN with empty scoreboard.

## Configuration
- FWD_WB_HOLD_EN defined: WB-slot matches forward via 011 (register file is read-before-write).
- Undefined: register file is write-through; WB matches yield 000, and 011 is never produced.

## Structure
- Shared package: select encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_WBHOLD, SEL_ALT), FSM state encoding, scoreboard slot struct.
- One sub-module: fwd_sel_pick, the combinational priority select per operand, instantiated twice (A, B).

## Test plan
- add x5 followed by sub using x5 as rs1 → fwd_a_sel=001 in EX, no stall.
- lw x6 followed by add using x6 as rs2 → stall=bubble=1 for one cycle, then fwd_b_sel=010.
- Producer of x7, two unrelated ops, then consumer of x7 → 011 with FWD_WB_HOLD_EN, 000 without.
- Consumer of x0 with producer writing x0 in EX → sel 000; auipc → fwd_a_sel=100.
- Load-use hazard coincident with flush → no stall, bubble=1, scoreboard EX/ID cleared.
- mem_wait high 3 cycles during a dependent pair → freeze=1 for 3 cycles, selects unchanged, correct forwarding resumes; reset asserted mid-freeze → RUN, all outputs zero.

Source files
------------

// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// mux select encodings, controller state encoding, scoreboard slot layout
// and the register-match helper used by both the hazard logic and the
// per-operand select pickers.
package operand_fwd_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 3;

    // Operand mux select encodings (101-111 are never driven)
    localparam logic [SEL_W-1:0] SEL_RF     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_EXMEM  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_MEMWB  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_WBHOLD = 3'b011;
    localparam logic [SEL_W-1:0] SEL_ALT    = 3'b100;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_FREEZE     = 2'b10
    } fwd_state_e;

    // One in-flight instruction as seen by the scoreboard
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    // A slot produces a value for rs only if it really writes a non-x0 register
    function automatic logic slot_hit(input sb_slot_t slot, input logic [REG_W-1:0] rs);
        return slot.valid && slot.reg_write && (slot.rd != '0) && (slot.rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd_ctrl_fwd_sel_pick.sv
// Combinational priority select for one EX-stage operand mux.
// The youngest in-flight producer wins; the alternate source (PC or
// immediate) overrides everything.
// Optional feature macro: FWD_WB_HOLD_EN -- when defined, a match in the
// WB slot forwards from the WB-hold register; otherwise the register file
// is write-through and a WB match simply reads the register file.
module fwd_sel_pick
    import operand_fwd_ctrl_pkg::*;
(
    input  logic             use_i,
    input  logic             alt_i,
    input  logic [REG_W-1:0] rs_i,
    input  sb_slot_t         ex_slot_i,
    input  sb_slot_t         mem_slot_i,
    input  sb_slot_t         wb_slot_i,
    output logic [SEL_W-1:0] sel_o
);

    // Priority chain: alternate, unused, EX, MEM, WB, register file
    always_comb begin
        sel_o = SEL_RF;
        if (alt_i) begin
            sel_o = SEL_ALT;
        end else if (!use_i) begin
            sel_o = SEL_RF;
        end else if (slot_hit(ex_slot_i, rs_i)) begin
            sel_o = SEL_EXMEM;
        end else if (slot_hit(mem_slot_i, rs_i)) begin
            sel_o = SEL_MEMWB;
        end else if (slot_hit(wb_slot_i, rs_i)) begin
`ifdef FWD_WB_HOLD_EN
            sel_o = SEL_WBHOLD;
`else
            sel_o = SEL_RF;
`endif
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Sequencing controller for the EX-stage operand muxes of the five-stage
// pipeline. Tracks in-flight destinations in a three-slot scoreboard
// (EX, MEM, WB), registers the operand selects so they line up with the
// instruction in EX, and produces load-use stall/bubble and memory-wait
// freeze controls.
// Optional feature macro: FWD_WB_HOLD_EN (see fwd_sel_pick).
module operand_fwd_ctrl
    import operand_fwd_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             id_alt_a_i,
    input  logic             id_alt_b_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_is_load_i,
    input  logic             flush_i,
    input  logic             mem_wait_i,
    output logic [SEL_W-1:0] fwd_a_sel_o,
    output logic [SEL_W-1:0] fwd_b_sel_o,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             freeze_o
);

    fwd_state_e       state_q, state_d;
    sb_slot_t         ex_q, ex_d;
    sb_slot_t         mem_q, mem_d;
    sb_slot_t         wb_q, wb_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic [SEL_W-1:0] pick_a, pick_b;
    logic             load_use;
    sb_slot_t         id_slot;

    fwd_sel_pick u_pick_a (
        .use_i      (id_use_rs1_i),
        .alt_i      (id_alt_a_i),
        .rs_i       (id_rs1_i),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .wb_slot_i  (wb_q),
        .sel_o      (pick_a)
    );

    fwd_sel_pick u_pick_b (
        .use_i      (id_use_rs2_i),
        .alt_i      (id_alt_b_i),
        .rs_i       (id_rs2_i),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .wb_slot_i  (wb_q),
        .sel_o      (pick_b)
    );

    // Load-use hazard: a load in EX feeds a register operand of the ID instruction.
    // Right after a load stall EX holds the bubble, so no new hazard can arise there.
    always_comb begin
        load_use = 1'b0;
        if ((state_q != ST_LOAD_STALL) && id_valid_i && ex_q.is_load) begin
            load_use = (id_use_rs1_i && !id_alt_a_i && slot_hit(ex_q, id_rs1_i)) ||
                       (id_use_rs2_i && !id_alt_b_i && slot_hit(ex_q, id_rs2_i));
        end
    end

    // Pipeline controls: memory wait dominates, flush kills any load-use stall
    always_comb begin
        freeze_o = mem_wait_i;
        stall_o  = mem_wait_i || (load_use && !flush_i);
        bubble_o = !mem_wait_i && (flush_i || load_use);
    end

    // Next scoreboard, selects and controller state
    always_comb begin
        id_slot = '{valid: id_valid_i, rd: id_rd_i,
                    reg_write: id_reg_write_i, is_load: id_is_load_i};
        state_d = state_q;
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        case (state_q)
            ST_RUN, ST_LOAD_STALL, ST_FREEZE: begin
                if (mem_wait_i) begin
                    state_d = ST_FREEZE;
                end else begin
                    wb_d = mem_q;
                    if (flush_i) begin
                        state_d = ST_RUN;
                        ex_d    = SLOT_EMPTY;
                        mem_d   = SLOT_EMPTY;
                        sel_a_d = SEL_RF;
                        sel_b_d = SEL_RF;
                    end else if (load_use) begin
                        state_d = ST_LOAD_STALL;
                        ex_d    = SLOT_EMPTY;
                        mem_d   = ex_q;
                        sel_a_d = SEL_RF;
                        sel_b_d = SEL_RF;
                    end else begin
                        state_d = ST_RUN;
                        ex_d    = id_valid_i ? id_slot : SLOT_EMPTY;
                        mem_d   = ex_q;
                        sel_a_d = id_valid_i ? pick_a : SEL_RF;
                        sel_b_d = id_valid_i ? pick_b : SEL_RF;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous reset to an empty, running pipeline
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            wb_q    <= SLOT_EMPTY;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_a_sel_o = sel_a_q;
    assign fwd_b_sel_o = sel_b_q;

endmodule
